// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA timing definitions used by the timing generator
//                and the graphics stage. It holds the 10-bit coordinate type,
//                the default 640x480@60 geometry, the default animation
//                divider, and helpers that derive the line/frame totals and
//                the sync window bounds from a porch/sync geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

  typedef logic [9:0] coord_t;

  // Default 640x480 geometry (800 x 525 totals)
  localparam int C_H_VISIBLE   = 640;
  localparam int C_H_FP        = 16;
  localparam int C_H_SYNC      = 96;
  localparam int C_H_BP        = 48;
  localparam int C_V_VISIBLE   = 480;
  localparam int C_V_FP        = 10;
  localparam int C_V_SYNC      = 2;
  localparam int C_V_BP        = 33;
  localparam int C_ANIM_FRAMES = 8;

  // Total period (pixels per line or lines per frame)
  function automatic int timing_total(input int vis, input int fp,
                                      input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  // First count of the sync window
  function automatic int sync_first(input int vis, input int fp);
    return vis + fp;
  endfunction

  // Last count of the sync window (inclusive)
  function automatic int sync_last(input int vis, input int fp, input int sync);
    return vis + fp + sync - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_anim_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : vga_anim_ctr
//  Description : Sprite animation sequencer. Counts frame ticks modulo
//                ANIM_FRAMES; each terminal count toggles the ghost body
//                phase and advances the pacman mouth frame (0..3, wrapping).
//                The whole module exists only when VGA_TIMING_ANIM_EN is
//                defined.
//  Ports       : clk             in   system clock
//                rst             in   asynchronous active-high reset
//                frame_tick      in   one-cycle strobe, one per frame
//                ghost_animation out  ghost body phase
//                pacman_anim     out  pacman mouth frame
//  Macro       : VGA_TIMING_ANIM_EN
//  Revision    : 1.0  initial release
// ============================================================================
`ifdef VGA_TIMING_ANIM_EN
module vga_anim_ctr #(
  parameter int ANIM_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  output logic       ghost_animation,
  output logic [1:0] pacman_anim
);

  localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);

  logic [7:0] r_frame_cnt;
  logic       r_ghost;
  logic [1:0] r_pacman;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= 8'd0;
      r_ghost     <= 1'b0;
      r_pacman    <= 2'd0;
    end else if (frame_tick) begin
      if (r_frame_cnt == ANIM_LAST) begin
        r_frame_cnt <= 8'd0;
        r_ghost     <= ~r_ghost;
        r_pacman    <= (r_pacman == 2'd3) ? 2'd0 : r_pacman + 2'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign ghost_animation = r_ghost;
  assign pacman_anim     = r_pacman;

endmodule
`endif
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : VGA raster timing generator. A divide-by-two pixel strobe
//                advances the horizontal/vertical counters; sync, visible and
//                the frame/vblank pulses are registered from the next counter
//                values so they line up with hc/vc in the same cycle.
//  Ports       : clk             in   system clock (50 MHz)
//                rst             in   asynchronous active-high reset
//                pix_en          out  pixel strobe, high every second clk
//                hc / vc         out  horizontal / vertical count
//                hsync / vsync   out  active-low syncs
//                visible         out  inside the active picture
//                frame_start     out  one-clk pulse at hc=0, vc=0
//                vblank_start    out  one-clk pulse at hc=0, vc=V_VISIBLE
//                ghost_animation out  ghost body phase
//                pacman_anim     out  pacman mouth frame
//  Macro       : VGA_TIMING_ANIM_EN enables the animation sequencer;
//                otherwise the animation outputs are tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE   = C_H_VISIBLE,
  parameter int H_FP        = C_H_FP,
  parameter int H_SYNC      = C_H_SYNC,
  parameter int H_BP        = C_H_BP,
  parameter int V_VISIBLE   = C_V_VISIBLE,
  parameter int V_FP        = C_V_FP,
  parameter int V_SYNC      = C_V_SYNC,
  parameter int V_BP        = C_V_BP,
  parameter int ANIM_FRAMES = C_ANIM_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       frame_start,
  output logic       vblank_start,
  output logic       ghost_animation,
  output logic [1:0] pacman_anim
);

  localparam coord_t H_LAST   = coord_t'(timing_total(H_VISIBLE, H_FP, H_SYNC, H_BP) - 1);
  localparam coord_t V_LAST   = coord_t'(timing_total(V_VISIBLE, V_FP, V_SYNC, V_BP) - 1);
  localparam coord_t HS_FIRST = coord_t'(sync_first(H_VISIBLE, H_FP));
  localparam coord_t HS_LAST  = coord_t'(sync_last(H_VISIBLE, H_FP, H_SYNC));
  localparam coord_t VS_FIRST = coord_t'(sync_first(V_VISIBLE, V_FP));
  localparam coord_t VS_LAST  = coord_t'(sync_last(V_VISIBLE, V_FP, V_SYNC));
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);

  logic   r_pix_en;
  coord_t r_hc;
  coord_t r_vc;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_visible;
  logic   r_frame_start;
  logic   r_vblank_start;

  logic   w_h_wrap;
  coord_t w_hc_next;
  coord_t w_vc_next;
  logic   w_frame_tick;
  logic   w_vblank_tick;

  // Compare-and-clear counters: neither count ever passes its terminal value.
  always_comb begin
    w_h_wrap  = (r_hc == H_LAST);
    w_hc_next = w_h_wrap ? '0 : r_hc + 10'd1;
    w_vc_next = r_vc;
    if (w_h_wrap) begin
      w_vc_next = (r_vc == V_LAST) ? '0 : r_vc + 10'd1;
    end
  end

  // Pulses are qualified by the strobe, so they fire only on the edge where
  // the qualifying count is loaded and clear on the following clk edge.
  assign w_frame_tick  = r_pix_en && (w_hc_next == '0) && (w_vc_next == '0);
  assign w_vblank_tick = r_pix_en && (w_hc_next == '0) && (w_vc_next == V_VIS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_en       <= 1'b0;
      r_hc           <= '0;
      r_vc           <= '0;
      r_hsync        <= 1'b1;
      r_vsync        <= 1'b1;
      r_visible      <= 1'b1;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
    end else begin
      r_pix_en       <= ~r_pix_en;
      r_frame_start  <= w_frame_tick;
      r_vblank_start <= w_vblank_tick;
      if (r_pix_en) begin
        r_hc      <= w_hc_next;
        r_vc      <= w_vc_next;
        // Decoded from the next counts so they align with hc/vc.
        r_hsync   <= !((w_hc_next >= HS_FIRST) && (w_hc_next <= HS_LAST));
        r_vsync   <= !((w_vc_next >= VS_FIRST) && (w_vc_next <= VS_LAST));
        r_visible <= (w_hc_next < H_VIS) && (w_vc_next < V_VIS);
      end
    end
  end

  assign pix_en       = r_pix_en;
  assign hc           = r_hc;
  assign vc           = r_vc;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign visible      = r_visible;
  assign frame_start  = r_frame_start;
  assign vblank_start = r_vblank_start;

`ifdef VGA_TIMING_ANIM_EN
  vga_anim_ctr #(
    .ANIM_FRAMES (ANIM_FRAMES)
  ) u_anim_ctr (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (w_frame_tick),
    .ghost_animation (ghost_animation),
    .pacman_anim     (pacman_anim)
  );
`else
  assign ghost_animation = 1'b0;
  assign pacman_anim     = 2'd0;

  // ANIM_FRAMES has no function without the sequencer.
  logic w_unused_anim;
  assign w_unused_anim = ^{1'b0, 8'(ANIM_FRAMES), w_frame_tick};
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing
//  Description : Self-checking bench for vga_timing on a reduced geometry
//                (25 x 17 totals) so several frames fit in a short run.
//                Expected values come from a closed-form model indexed by
//                the number of clk edges since reset release.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int AF = 2;
  localparam int HT = HV + HF + HS + HB;   // 25
  localparam int VT = VV + VF + VS + VB;   // 17
  localparam int FRAME = HT * VT;          // 425 strobes
`ifdef VGA_TIMING_ANIM_EN
  localparam bit ANIM_ON = 1'b1;
`else
  localparam bit ANIM_ON = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       pix;
    logic       hs;
    logic       vs;
    logic       vis;
    logic       fs;
    logic       vb;
    logic       g;
    logic [1:0] p;
  } obs_t;

  typedef struct {
    int   clk_n;
    obs_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en, hsync, vsync, visible, frame_start, vblank_start, ghost_animation;
  logic [9:0] hc, vc;
  logic [1:0] pacman_anim;

  int k = 0;          // clk edges since reset release
  int passed = 0;
  int total = 0;

  vga_timing #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ANIM_FRAMES(AF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pix_en          (pix_en),
    .hc              (hc),
    .vc              (vc),
    .hsync           (hsync),
    .vsync           (vsync),
    .visible         (visible),
    .frame_start     (frame_start),
    .vblank_start    (vblank_start),
    .ghost_animation (ghost_animation),
    .pacman_anim     (pacman_anim)
  );

  always #5 clk = ~clk;

  // Reference: everything follows from the strobe count n = k/2.
  function automatic obs_t model(input int kk);
    obs_t o;
    int n, h, v, t;
    n = kk / 2;
    h = n % HT;
    v = (n / HT) % VT;
    t = (n / FRAME) / AF;
    o.hc  = 10'(h);
    o.vc  = 10'(v);
    o.pix = (kk % 2) == 1;
    o.hs  = !(h >= HV + HF && h < HV + HF + HS);
    o.vs  = !(v >= VV + VF && v < VV + VF + VS);
    o.vis = (h < HV) && (v < VV);
    o.fs  = (kk > 0) && (kk % 2 == 0) && (h == 0) && (v == 0);
    o.vb  = (kk > 0) && (kk % 2 == 0) && (h == 0) && (v == VV);
    o.g   = ANIM_ON && (t % 2 == 1);
    o.p   = ANIM_ON ? 2'(t % 4) : 2'd0;
    return o;
  endfunction

  function automatic obs_t mk(input int h, input int v, input bit pe, input bit hs_, input bit vs_,
                              input bit vis_, input bit fs_, input bit vb_, input bit g_, input int p_);
    obs_t o;
    o.hc = 10'(h); o.vc = 10'(v); o.pix = pe; o.hs = hs_; o.vs = vs_; o.vis = vis_;
    o.fs = fs_; o.vb = vb_;
    o.g  = ANIM_ON & g_;
    o.p  = ANIM_ON ? 2'(p_) : 2'd0;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.hc = hc; o.vc = vc; o.pix = pix_en; o.hs = hsync; o.vs = vsync; o.vis = visible;
    o.fs = frame_start; o.vb = vblank_start; o.g = ghost_animation; o.p = pacman_anim;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("hc=%0d vc=%0d pix=%0b hs=%0b vs=%0b vis=%0b fs=%0b vb=%0b g=%0b p=%0d",
                     o.hc, o.vc, o.pix, o.hs, o.vs, o.vis, o.fs, o.vb, o.g, o.p);
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s (k=%0d): got {%s} expected {%s}", name, k, fmt(got), fmt(exp));
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    k++;
    #1;
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic apply_reset();
    @(negedge clk);
    #($urandom_range(1, 3));
    rst = 1'b1;
    #1;
    check_obs("reset_async", sample(), model(0));
    repeat (2) @(posedge clk);
    #1;
    check_obs("reset_held", sample(), model(0));
    @(negedge clk);
    rst = 1'b0;
    k = 0;
  endtask

  vec_t vecs[18];

  initial begin
    int fs_cnt, vb_cnt, vb_hc, vb_vc, hmax, vmax, bad, hs_low, hs_first, vis_fall;
    int toggles, any_anim, waited;
    logic [31:0] vs_lines;
    logic [9:0]  prev_hc;
    logic        prev_pix, prev_g;
    logic [1:0]  prev_p;
    int pq[$];

    // ---- directed vectors: {clk edges since release, expected outputs} ----
    //                 hc  vc pix hs vs vis fs vb g  p
    vecs[0]  = '{0,    mk(0,  0, 0, 1, 1, 1, 0, 0, 0, 0)};
    vecs[1]  = '{1,    mk(0,  0, 1, 1, 1, 1, 0, 0, 0, 0)};
    vecs[2]  = '{2,    mk(1,  0, 0, 1, 1, 1, 0, 0, 0, 0)};
    vecs[3]  = '{32,   mk(16, 0, 0, 1, 1, 0, 0, 0, 0, 0)};
    vecs[4]  = '{35,   mk(17, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
    vecs[5]  = '{36,   mk(18, 0, 0, 0, 1, 0, 0, 0, 0, 0)};
    vecs[6]  = '{43,   mk(21, 0, 1, 0, 1, 0, 0, 0, 0, 0)};
    vecs[7]  = '{44,   mk(22, 0, 0, 1, 1, 0, 0, 0, 0, 0)};
    vecs[8]  = '{50,   mk(0,  1, 0, 1, 1, 1, 0, 0, 0, 0)};
    vecs[9]  = '{500,  mk(0, 10, 0, 1, 1, 0, 0, 1, 0, 0)};
    vecs[10] = '{501,  mk(0, 10, 1, 1, 1, 0, 0, 0, 0, 0)};
    vecs[11] = '{600,  mk(0, 12, 0, 1, 0, 0, 0, 0, 0, 0)};
    vecs[12] = '{650,  mk(0, 13, 0, 1, 0, 0, 0, 0, 0, 0)};
    vecs[13] = '{700,  mk(0, 14, 0, 1, 1, 0, 0, 0, 0, 0)};
    vecs[14] = '{849,  mk(24, 16, 1, 1, 1, 0, 0, 0, 0, 0)};
    vecs[15] = '{850,  mk(0,  0, 0, 1, 1, 1, 1, 0, 0, 0)};
    vecs[16] = '{851,  mk(0,  0, 1, 1, 1, 1, 0, 0, 0, 0)};
    vecs[17] = '{1700, mk(0,  0, 0, 1, 1, 1, 1, 0, 1, 1)};

    apply_reset();
    for (int i = 0; i < 18; i++) begin
      while (k < vecs[i].clk_n) tick();
      check_obs($sformatf("vec%0d", i), sample(), vecs[i].exp);
    end

    // ---- one frame after release: pulses, maxima, line and frame shape ----
    apply_reset();
    fs_cnt = 0; vb_cnt = 0; vb_hc = -1; vb_vc = -1; hmax = 0; vmax = 0; bad = 0;
    hs_low = 0; hs_first = -1; vis_fall = -1; vs_lines = '0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      prev_hc  = hc;
      prev_pix = pix_en;
      tick();
      if (frame_start) fs_cnt++;
      if (vblank_start) begin vb_cnt++; vb_hc = int'(hc); vb_vc = int'(vc); end
      if (int'(hc) > hmax) hmax = int'(hc);
      if (int'(vc) > vmax) vmax = int'(vc);
      if (hc != prev_hc && !prev_pix) bad++;
      if (vc == 10'd0 && !pix_en) begin
        if (!hsync) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(hc);
        end
        if (!visible && vis_fall < 0) vis_fall = int'(hc);
      end
      if (!vsync) vs_lines[vc[4:0]] = 1'b1;
    end
    check_int("frame_start_count", fs_cnt, 1);
    check_int("hc_max", hmax, HT - 1);
    check_int("vc_max", vmax, VT - 1);
    check_int("hc_only_on_strobe", bad, 0);
    check_int("hsync_low_strobes", hs_low, HS);
    check_int("hsync_first_hc", hs_first, HV + HF);
    check_int("visible_fall_hc", vis_fall, HV);
    check_int("vsync_lines", int'(vs_lines), (1 << (VV + VF)) | (1 << (VV + VF + 1)));
    check_int("vblank_count", vb_cnt, 1);
    check_int("vblank_vc", vb_vc, VV);
    check_int("vblank_hc", vb_hc, 0);

    // ---- animation over 8 frames ----
    apply_reset();
    toggles = 0; any_anim = 0; pq.delete();
    prev_g = ghost_animation; prev_p = pacman_anim;
    for (int i = 0; i < 16 * FRAME; i++) begin
      tick();
      if (ghost_animation != prev_g) toggles++;
      if (pacman_anim != prev_p) pq.push_back(int'(pacman_anim));
      if (ghost_animation || pacman_anim != 2'd0) any_anim = 1;
      prev_g = ghost_animation;
      prev_p = pacman_anim;
    end
    check_int("ghost_toggles", toggles, ANIM_ON ? 4 : 0);
    check_int("pacman_seq_len", pq.size(), ANIM_ON ? 4 : 0);
    check_int("anim_activity", any_anim, ANIM_ON ? 1 : 0);
    for (int i = 0; i < pq.size() && i < 4; i++)
      check_int($sformatf("pacman_seq%0d", i), pq[i], (i + 1) % 4);

    // ---- mid-frame reset, then a full frame until the next frame_start ----
    apply_reset();
    while (k < 2 * (2 * FRAME + 5 * HT + 10)) tick();
    check_obs("pre_reset_state", sample(), model(k));
    apply_reset();
    waited = -1;
    fs_cnt = 0;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      tick();
      if (frame_start) begin
        if (fs_cnt == 0) waited = k;
        fs_cnt++;
      end
    end
    check_int("frame_after_reset_clks", waited, 2 * FRAME);

    // ---- randomized runs with async resets against the model ----
    for (int r = 0; r < 6; r++) begin
      int len;
      apply_reset();
      len = $urandom_range(50, 2000);
      for (int i = 0; i < len; i++) begin
        tick();
        check_obs("random", sample(), model(k));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
